ps2_host_tx: RTL

//  Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xED set-LEDs, 0xFF reset) to the keyboard.
//  It is the opposite direction of the board's PS/2 scan-code receive path and shares the PS2_CLK and PS2_DAT pins.

---
 rtl/ps2_host_tx.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, requests to send, clocks one
// command byte out on device-generated clock falls and collects the device ACK.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 2700,
  parameter int TIMEOUT_CYCLES = 405000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_error,
  output logic       busy,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe
);

  localparam int MaxCount = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int TW       = $clog2(MaxCount + 1);

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    SEND,
    ACK,
    WAIT_IDLE
  } state_e;

  state_e          state_q;
  logic            clkMeta_q, clkSync_q, clkPrev_q;
  logic            datMeta_q, datSync_q;
  logic            clkOe_q, datOe_q;
  logic            done_q, error_q;
  logic            ackOk_q;
  logic [9:0]      shreg_q;
  logic [3:0]      bitCnt_q;
  logic [TW-1:0]   timer_q;
  logic            fall;
  logic            timedState;

  // Lines idle high, so the synchronisers reset to 1 to avoid a false fall after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      clkMeta_q <= 1'b1;
      clkSync_q <= 1'b1;
      clkPrev_q <= 1'b1;
      datMeta_q <= 1'b1;
      datSync_q <= 1'b1;
    end else begin
      clkMeta_q <= ps2_clk_in;
      clkSync_q <= clkMeta_q;
      clkPrev_q <= clkSync_q;
      datMeta_q <= ps2_dat_in;
      datSync_q <= datMeta_q;
    end
  end

  assign fall       = clkPrev_q & ~clkSync_q;
  assign timedState = (state_q == SEND) || (state_q == ACK) || (state_q == WAIT_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      clkOe_q  <= 1'b0;
      datOe_q  <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
      ackOk_q  <= 1'b0;
      shreg_q  <= '0;
      bitCnt_q <= '0;
      timer_q  <= '0;
    end else begin
      done_q  <= 1'b0;
      error_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (tx_valid) begin
            shreg_q  <= {1'b1, ~^tx_data, tx_data};
            bitCnt_q <= '0;
            timer_q  <= '0;
            clkOe_q  <= 1'b1;
            state_q  <= INHIBIT;
          end
        end
        INHIBIT: begin
          timer_q <= timer_q + 1'b1;
          // Start bit goes out on the last inhibit cycle so DAT is low when CLK is released.
          if (timer_q == TW'(INHIBIT_CYCLES - 2)) datOe_q <= 1'b1;
          if (timer_q == TW'(INHIBIT_CYCLES - 1)) begin
            clkOe_q <= 1'b0;
            timer_q <= '0;
            state_q <= SEND;
          end
        end
        SEND: begin
          if (fall) begin
            datOe_q  <= ~shreg_q[0];
            shreg_q  <= {1'b0, shreg_q[9:1]};
            bitCnt_q <= bitCnt_q + 1'b1;
            if (bitCnt_q == 4'd9) state_q <= ACK;
          end
        end
        ACK: begin
          if (fall) begin
            ackOk_q <= ~datSync_q;
            state_q <= WAIT_IDLE;
          end
        end
        WAIT_IDLE: begin
          if (clkSync_q && datSync_q) begin
            done_q  <= ackOk_q;
            error_q <= ~ackOk_q;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase

      // Timeout overrides any completion in the same cycle so only one pulse ever fires.
      if (timedState) begin
        if (fall) begin
          timer_q <= '0;
        end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
          timer_q <= '0;
          done_q  <= 1'b0;
          error_q <= 1'b1;
          clkOe_q <= 1'b0;
          datOe_q <= 1'b0;
          state_q <= IDLE;
        end else begin
          timer_q <= timer_q + 1'b1;
        end
      end
    end
  end

  assign tx_ready   = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign tx_done    = done_q;
  assign tx_error   = error_q;
  assign ps2_clk_oe = clkOe_q;
  assign ps2_dat_oe = datOe_q;

endmodule
